// File: rtl/edge_detector_pkg.sv
// Shared definitions for the edge detector: edge-mode encodings, defaults
// and small helpers used by the detector and its delay chain.
package edge_detector_pkg;

    // Selected edge polarity; encodings are fixed and shared with users.
    typedef enum logic [1:0] {
        RISE = 2'd0,
        FALL = 2'd1,
        BOTH = 2'd2
    } edge_mode_e;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned MAX_SYNC_STAGES    = 3;

    // Level that trig_prev takes in reset, so that a trigger already sitting
    // at the active level is seen as an edge once reset is released.
    function automatic logic inactive_level(input edge_mode_e mode);
        return (mode == FALL) ? 1'b1 : 1'b0;
    endfunction

    // True when the current/previous trigger samples form an edge of the
    // selected kind.
    function automatic logic edge_seen(input edge_mode_e mode,
                                       input logic       cur,
                                       input logic       prev);
        logic hit;
        hit = 1'b0;
        unique case (mode)
            RISE:    hit = cur & ~prev;
            FALL:    hit = ~cur & prev;
            BOTH:    hit = cur ^ prev;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/edge_detector_sync.sv
// Parameterised-depth delay chain carrying trigger and payload together so
// they stay cycle-aligned. DEPTH=0 is a plain wire.
module edge_detector_sync
    import edge_detector_pkg::*;
#(
    parameter int unsigned DEPTH = 0,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign dout           = din;
        end else begin : g_chain
            logic [WIDTH-1:0] stage [DEPTH];

            // Shift register; all stages clear on reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        stage[i] <= '0;
                    end
                end else begin
                    stage[0] <= din;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/edge_detector.sv
// Edge detector: optionally synchronises trigger (with payload delayed in
// step), detects the selected edge and emits a registered one-cycle pulse
// together with the payload captured at that edge.
module edge_detector
    import edge_detector_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter edge_mode_e  EDGE_MODE   = RISE,
    parameter int unsigned SYNC_STAGES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trigger,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  trigger_out,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int unsigned CHAIN_W   = DATA_WIDTH + 1;
    localparam logic        PREV_INIT = inactive_level(EDGE_MODE);

    logic [CHAIN_W-1:0]    chain_in;
    logic [CHAIN_W-1:0]    chain_out;
    logic                  trig_s;
    logic [DATA_WIDTH-1:0] data_s;
    logic                  trig_prev;
    logic                  edge_hit;

    // Trigger rides in the MSB so a single chain keeps it aligned with data.
    assign chain_in = {trigger, data};

    edge_detector_sync #(
        .DEPTH (SYNC_STAGES),
        .WIDTH (CHAIN_W)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (chain_in),
        .dout (chain_out)
    );

    assign trig_s = chain_out[DATA_WIDTH];
    assign data_s = chain_out[DATA_WIDTH-1:0];

    // Previous trigger sample; reset to the inactive level of the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_prev <= PREV_INIT;
        end else begin
            trig_prev <= trig_s;
        end
    end

    // Edge decode for the selected mode.
    always_comb begin
        edge_hit = 1'b0;
        edge_hit = edge_seen(EDGE_MODE, trig_s, trig_prev);
    end

    // Registered pulse and payload capture; payload holds between edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            trigger_out <= 1'b0;
            data_out    <= '0;
        end else begin
            trigger_out <= edge_hit;
            if (edge_hit) begin
                data_out <= data_s;
            end
        end
    end

endmodule

// File: tb/tb_edge_detector.sv
// Self-checking bench for edge_detector: four instances (RISE default,
// FALL, BOTH, RISE with two sync stages) driven independently; expected
// pulses are queued at stimulus time and matched against observed pulses.
module tb_edge_detector;
    import edge_detector_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       trig [4];
    logic [7:0] dat  [4];
    logic       tout [4];
    logic [7:0] dout [4];

    always #5 clk = ~clk;

    edge_detector u_rise (
        .clk(clk), .rst(rst), .trigger(trig[0]), .data(dat[0]),
        .trigger_out(tout[0]), .data_out(dout[0])
    );

    edge_detector #(.EDGE_MODE(FALL)) u_fall (
        .clk(clk), .rst(rst), .trigger(trig[1]), .data(dat[1]),
        .trigger_out(tout[1]), .data_out(dout[1])
    );

    edge_detector #(.EDGE_MODE(BOTH)) u_both (
        .clk(clk), .rst(rst), .trigger(trig[2]), .data(dat[2]),
        .trigger_out(tout[2]), .data_out(dout[2])
    );

    edge_detector #(.SYNC_STAGES(2)) u_sync2 (
        .clk(clk), .rst(rst), .trigger(trig[3]), .data(dat[3]),
        .trigger_out(tout[3]), .data_out(dout[3])
    );

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q [$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   sel      = 0;
    logic last_trig [4];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference edge rule per instance: 1=FALL, 2=BOTH, others RISE.
    function automatic logic is_edge(input int id, input logic p, input logic n);
        case (id)
            1:       return p & ~n;
            2:       return p ^ n;
            default: return ~p & n;
        endcase
    endfunction

    function automatic int latency(input int id);
        return (id == 3) ? 3 : 1;
    endfunction

    // Scoreboard: every pulse on the selected instance must match the head
    // of the expected queue; an overdue expectation is a missing pulse.
    always @(negedge clk) begin
        if (tout[sel] === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse dut=%0d cyc=%0d data_out=%02h required=no pulse",
                         sel, cyc, dout[sel]);
            end else begin
                mon_e = exp_q.pop_front();
                if (cyc !== mon_e.cyc || dout[sel] !== mon_e.data) begin
                    failures++;
                    $display("FAIL pulse dut=%0d got cyc=%0d data=%02h required cyc=%0d data=%02h",
                             sel, cyc, dout[sel], mon_e.cyc, mon_e.data);
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            checks++;
            failures++;
            mon_e = exp_q.pop_front();
            $display("FAIL missing_pulse dut=%0d got none at cyc=%0d required data=%02h at cyc=%0d",
                     sel, cyc, mon_e.data, mon_e.cyc);
        end
    end

    task automatic drive(input int id, input logic t, input logic [7:0] d);
        @(posedge clk);
        #2;
        if (id == sel && is_edge(id, last_trig[id], t))
            exp_q.push_back('{cyc + latency(id), d});
        trig[id]      = t;
        dat[id]       = d;
        last_trig[id] = t;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tout[i] !== 1'b0) begin
                failures++;
                $display("FAIL reset_trigger_out dut=%0d got=%b required=0", i, tout[i]);
            end
            checks++;
            if (dout[i] !== 8'h00) begin
                failures++;
                $display("FAIL reset_data_out dut=%0d got=%02h required=00", i, dout[i]);
            end
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_rise_hold;
        sel = 0;
        drive(0, 1'b1, 8'hEE);
        for (int i = 0; i < 50; i++) begin
            drive(0, 1'b1, 8'($urandom));
            if (i == 10) begin
                #1;
                checks++;
                if (dout[0] !== 8'hEE) begin
                    failures++;
                    $display("FAIL hold_data_mid got=%02h required=EE", dout[0]);
                end
            end
        end
        #1;
        checks++;
        if (dout[0] !== 8'hEE) begin
            failures++;
            $display("FAIL hold_data_end got=%02h required=EE", dout[0]);
        end
        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL hold_queue pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back;
        sel = 0;
        drive(0, 1'b0, 8'h10);
        drive(0, 1'b0, 8'h11);
        drive(0, 1'b1, 8'h33);
        drive(0, 1'b0, 8'h00);
        drive(0, 1'b1, 8'hEE);
        for (int i = 0; i < 4; i++) drive(0, 1'b1, 8'h00);
        #1;
        checks++;
        if (dout[0] !== 8'hEE) begin
            failures++;
            $display("FAIL regrise_data got=%02h required=EE", dout[0]);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL regrise_queue pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_fall;
        sel = 1;
        drive(1, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h07);
        drive(1, 1'b1, 8'h11);
        drive(1, 1'b0, 8'h22);
        for (int i = 0; i < 4; i++) drive(1, 1'b0, 8'h99);
        #1;
        checks++;
        if (dout[1] !== 8'h22) begin
            failures++;
            $display("FAIL fall_data got=%02h required=22", dout[1]);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL fall_queue pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_both;
        logic [7:0] d;
        sel = 2;
        drive(2, 1'b1, 8'h11);
        drive(2, 1'b0, 8'h22);
        drive(2, 1'b0, 8'h55);
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            drive(2, ~last_trig[2], d);
        end
        for (int i = 0; i < 3; i++) drive(2, last_trig[2], 8'hA5);
        #1;
        checks++;
        if (dout[2] !== d) begin
            failures++;
            $display("FAIL both_toggle_data got=%02h required=%02h", dout[2], d);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL both_queue pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_sync2;
        sel = 3;
        drive(3, 1'b1, 8'h5A);
        for (int i = 0; i < 6; i++) drive(3, 1'b1, 8'hC3);
        #1;
        checks++;
        if (dout[3] !== 8'h5A) begin
            failures++;
            $display("FAIL sync2_data got=%02h required=5A", dout[3]);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sync2_queue pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_reset_release;
        sel = 0;
        @(posedge clk);
        #2;
        rst     = 1'b1;
        trig[0] = 1'b0;
        dat[0]  = 8'h3C;
        trig[1] = 1'b1;
        @(posedge clk);
        #2;
        trig[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (tout[0] !== 1'b0) begin
                failures++;
                $display("FAIL edge_in_reset cycle=%0d got=%b required=0", i, tout[0]);
            end
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        exp_q.push_back('{cyc + 1, 8'h3C});
        last_trig[0] = 1'b1;
        last_trig[1] = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (dout[0] !== 8'h3C) begin
            failures++;
            $display("FAIL release_data got=%02h required=3C", dout[0]);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL release_queue pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_pulse;
        sel = 2;
        for (int i = 0; i < 4; i++) drive(2, ~last_trig[2], 8'h40 + 8'(i));
        @(posedge clk);
        #2;
        trig[2] = ~trig[2];
        dat[2]  = 8'hF0;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (tout[2] !== 1'b0) begin
            failures++;
            $display("FAIL midpulse_trigger_out got=%b required=0", tout[2]);
        end
        checks++;
        if (dout[2] !== 8'h00) begin
            failures++;
            $display("FAIL midpulse_data_out got=%02h required=00", dout[2]);
        end
        trig[2] = 1'b0;
        @(posedge clk);
        #2;
        rst          = 1'b0;
        last_trig[2] = 1'b0;
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL midpulse_queue pending=%0d required=0", exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            trig[i]      = (i == 1) ? 1'b1 : 1'b0;
            dat[i]       = 8'h00;
            last_trig[i] = trig[i];
        end
        test_reset();
        test_rise_hold();
        test_back_to_back();
        test_fall();
        test_both();
        test_sync2();
        test_reset_release();
        test_reset_mid_pulse();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
